// File: rtl/ov7670_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_pkg
//   Shared definitions for the OV7670 DVP capture front-end.
//   - MODE_* selectors for the pixel format produced from a byte pair
//   - default sensor timing (640x480 active window)
//   - capture-state enum used by the top-level sync tracker
//   - pixel packing helpers turning the {hi,lo} byte pair into a 16-bit word
// ---------------------------------------------------------------------------
package ov7670_pkg;

  localparam int MODE_RGB444 = 0;
  localparam int MODE_RGB565 = 1;
  localparam int MODE_Y8     = 2;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  // WAIT_SYNC: after reset, nothing is captured until a vsync has been seen,
  // so a reset in the middle of a line never produces writes from a
  // half-observed frame.
  typedef enum logic [1:0] {
    ST_WAIT_SYNC = 2'd0,
    ST_VBLANK    = 2'd1,
    ST_ACTIVE    = 2'd2
  } cap_state_e;

  // RGB444: R = hi[7:4], G = {hi[2:0], lo[7]}, B = lo[4:1]; hi[3], lo[6:5]
  // and lo[0] are the low-order bits the sensor emits in its 444 layout.
  function automatic logic [15:0] pack_rgb444(input logic [7:0] hi, input logic [7:0] lo);
    return {4'b0000, hi[7:4], hi[2:0], lo[7], lo[4:1]};
  endfunction

  function automatic logic [15:0] pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

  // YUV422 byte order U Y V Y: luma is the second byte of every pair.
  function automatic logic [15:0] pack_y8(input logic [7:0] lo);
    return {8'h00, lo};
  endfunction

  function automatic logic [15:0] pack_pixel(input logic [7:0] hi, input logic [7:0] lo,
                                             input int mode);
    case (mode)
      MODE_RGB565: return pack_rgb565(hi, lo);
      MODE_Y8:     return pack_y8(lo);
      default:     return pack_rgb444(hi, lo);
    endcase
  endfunction

endpackage

// File: rtl/ov7670_pixel_pack.sv
// ---------------------------------------------------------------------------
// ov7670_pixel_pack
//   Purely combinational byte-pair to pixel converter.
//   Parameters:
//     MODE   MODE_RGB444 / MODE_RGB565 / MODE_Y8 (see ov7670_pkg)
//   Ports:
//     hi     in  8   first byte of the pair (latched by the top)
//     lo     in  8   second byte of the pair (live sensor data)
//     pixel  out 16  packed pixel, zero-extended for the narrow formats
// ---------------------------------------------------------------------------
module ov7670_pixel_pack
  import ov7670_pkg::*;
#(
  parameter int MODE = MODE_RGB444
) (
  input  logic [7:0]  hi,
  input  logic [7:0]  lo,
  output logic [15:0] pixel
);

  always_comb begin
    pixel = pack_pixel(hi, lo, MODE);
  end

endmodule

// File: rtl/ov7670_capture_param.sv
// ---------------------------------------------------------------------------
// ov7670_capture_param
//   OV7670 DVP capture front-end in the sensor pclk domain. Pairs bytes into
//   pixels, optionally decimates 2:1 in both directions, and drives a linear
//   frame-buffer write port. Reports a per-frame done pulse and a sticky
//   line-length error.
//   Parameters:
//     H_ACTIVE  sensor pixels per line (byte pairs per href)
//     V_ACTIVE  sensor lines per frame
//     DECIM     0 = full resolution, 1 = keep even-x / even-y pixels only
//     MODE      MODE_RGB444 / MODE_RGB565 / MODE_Y8
//     ADDR_W    write address width, 2**ADDR_W >= H_OUT*V_OUT
//   Ports:
//     pclk        in   1       sensor pixel clock, rising edge
//     rst_n       in   1       asynchronous active-low reset
//     vsync       in   1       frame blanking, active high
//     href        in   1       line valid, active high
//     d           in   8       sensor data byte
//     addr        out  ADDR_W  frame-buffer write address
//     dout        out  16      packed pixel
//     we          out  1       write strobe, one pclk per stored pixel
//     frame_done  out  1       one-pclk pulse on vsync rise after a frame with writes
//     line_err    out  1       sticky per frame: a line had a bad byte/pixel count
// ---------------------------------------------------------------------------
module ov7670_capture_param
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int DECIM    = 0,
  parameter int MODE     = MODE_RGB444,
  parameter int ADDR_W   = 19
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout,
  output logic              we,
  output logic              frame_done,
  output logic              line_err
);

  // -------------------------------------------------------------------------
  // Derived sizes
  // -------------------------------------------------------------------------
  localparam int X_W   = $clog2(H_ACTIVE + 1);
  localparam int Y_W   = $clog2(V_ACTIVE + 1);
  localparam bit DEC_ON = (DECIM != 0);
  localparam int H_OUT = DEC_ON ? (H_ACTIVE / 2) : H_ACTIVE;
  localparam int V_OUT = DEC_ON ? (V_ACTIVE / 2) : V_ACTIVE;
  localparam int N_OUT = H_OUT * V_OUT;
  // One spare bit so the write counter can hold N_OUT even when it equals
  // 2**ADDR_W, which keeps the "no wrap" check exact.
  localparam int A_W   = ADDR_W + 1;

  localparam logic [X_W-1:0] X_END = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] Y_END = Y_W'(V_ACTIVE);
  localparam logic [A_W-1:0] A_END = A_W'(N_OUT);
  localparam logic [X_W-1:0] X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);
  localparam logic [A_W-1:0] A_ONE = A_W'(1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  cap_state_e        state_reg;
  cap_state_e        state_next;
  logic              capture_en;

  logic              vsync_q_reg;
  logic              href_q_reg;
  logic              phase_reg;
  logic [7:0]        hi_reg;
  logic [X_W-1:0]    x_reg;
  logic [Y_W-1:0]    y_reg;
  logic [A_W-1:0]    acnt_reg;
  logic              wrote_any_reg;

  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       dout_reg;
  logic              we_reg;
  logic              frame_done_reg;
  logic              line_err_reg;

  logic [15:0]       pixel;
  logic              keep;

  // -------------------------------------------------------------------------
  // Sync tracker FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_WAIT_SYNC;
    end else begin
      state_reg <= state_next;
    end
  end

  // Sync tracker FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_WAIT_SYNC: if (vsync)  state_next = ST_VBLANK;
      ST_VBLANK:    if (!vsync) state_next = ST_ACTIVE;
      ST_ACTIVE:    if (vsync)  state_next = ST_VBLANK;
      default:                  state_next = ST_WAIT_SYNC;
    endcase
  end

  // Sync tracker FSM: outputs. Capture is allowed once a vsync has been seen
  // and only while vsync is low, so href during blanking is ignored.
  always_comb begin
    capture_en = 1'b0;
    case (state_reg)
      ST_VBLANK, ST_ACTIVE: capture_en = !vsync;
      default:              capture_en = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Pixel packing: hi is the latched phase-0 byte, lo is the byte on d now.
  // -------------------------------------------------------------------------
  ov7670_pixel_pack #(
    .MODE (MODE)
  ) u_pack (
    .hi    (hi_reg),
    .lo    (d),
    .pixel (pixel)
  );

  // Keep rule for the pixel completing this cycle (x/y are its coordinates).
  always_comb begin
    keep = (x_reg < X_END) && (y_reg < Y_END) && (acnt_reg < A_END);
    if (DEC_ON && (x_reg[0] || y_reg[0])) begin
      keep = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: phase, counters, edge detect, write port, error/done flags
  // -------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q_reg    <= 1'b0;
      href_q_reg     <= 1'b0;
      phase_reg      <= 1'b0;
      hi_reg         <= 8'h00;
      x_reg          <= '0;
      y_reg          <= '0;
      acnt_reg       <= '0;
      wrote_any_reg  <= 1'b0;
      addr_reg       <= '0;
      dout_reg       <= 16'h0000;
      we_reg         <= 1'b0;
      frame_done_reg <= 1'b0;
      line_err_reg   <= 1'b0;
    end else begin
      vsync_q_reg    <= vsync;
      href_q_reg     <= href;
      we_reg         <= 1'b0;
      frame_done_reg <= 1'b0;

      if (vsync) begin
        x_reg     <= '0;
        y_reg     <= '0;
        acnt_reg  <= '0;
        addr_reg  <= '0;
        phase_reg <= 1'b0;
        // Close the previous frame exactly once, on the rising edge.
        if (!vsync_q_reg) begin
          frame_done_reg <= wrote_any_reg;
          line_err_reg   <= 1'b0;
          wrote_any_reg  <= 1'b0;
        end
      end else if (capture_en) begin
        if (href) begin
          phase_reg <= ~phase_reg;
          if (!phase_reg) begin
            hi_reg <= d;
          end else begin
            // x saturates so an over-long line cannot alias back into range.
            if (x_reg != X_END) begin
              x_reg <= x_reg + X_ONE;
            end
            if (keep) begin
              we_reg        <= 1'b1;
              dout_reg      <= pixel;
              addr_reg      <= acnt_reg[ADDR_W-1:0];
              acnt_reg      <= acnt_reg + A_ONE;
              wrote_any_reg <= 1'b1;
            end
          end
        end else if (href_q_reg) begin
          // End of line: an odd byte count or a short line is an error; any
          // dangling phase-0 byte is simply dropped.
          if (phase_reg || (x_reg != X_END)) begin
            line_err_reg <= 1'b1;
          end
          x_reg     <= '0;
          phase_reg <= 1'b0;
          if (y_reg != Y_END) begin
            y_reg <= y_reg + Y_ONE;
          end
        end
      end
    end
  end

  assign addr       = addr_reg;
  assign dout       = dout_reg;
  assign we         = we_reg;
  assign frame_done = frame_done_reg;
  assign line_err   = line_err_reg;

endmodule

// File: tb/tb_ov7670_capture_param.sv
module tb_ov7670_capture_param;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic       vsync;
  logic       href;
  logic [7:0] d;

  always #5 pclk = ~pclk;

  // Four DUTs share the sensor pins: three 4x2 full-res (one per format) and
  // one 8x6 decimating RGB565 instance.
  logic [7:0]  a565, a444, ay8;
  logic [3:0]  adec;
  logic [15:0] d565, d444, dy8, ddec;
  logic        we565, we444, wey8, wedec;
  logic        fd565, fd444, fdy8, fddec;
  logic        le565, le444, ley8, ledec;

  ov7670_capture_param #(.H_ACTIVE(4), .V_ACTIVE(2), .DECIM(0), .MODE(1), .ADDR_W(8)) dut565 (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d),
    .addr(a565), .dout(d565), .we(we565), .frame_done(fd565), .line_err(le565));
  ov7670_capture_param #(.H_ACTIVE(4), .V_ACTIVE(2), .DECIM(0), .MODE(0), .ADDR_W(8)) dut444 (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d),
    .addr(a444), .dout(d444), .we(we444), .frame_done(fd444), .line_err(le444));
  ov7670_capture_param #(.H_ACTIVE(4), .V_ACTIVE(2), .DECIM(0), .MODE(2), .ADDR_W(8)) duty8 (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d),
    .addr(ay8), .dout(dy8), .we(wey8), .frame_done(fdy8), .line_err(ley8));
  ov7670_capture_param #(.H_ACTIVE(8), .V_ACTIVE(6), .DECIM(1), .MODE(1), .ADDR_W(4)) dutdec (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d),
    .addr(adec), .dout(ddec), .we(wedec), .frame_done(fddec), .line_err(ledec));

  typedef struct {
    int          a;
    logic [15:0] v;
  } wr_t;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] e444;
    logic [15:0] e565;
    logic [15:0] ey8;
  } vec_t;

  wr_t  q565[$], q444[$], qy8[$], qdec[$];
  int   fdc565, fdc444, fdcy8, fdcdec;
  int   total = 0;
  int   bad   = 0;
  vec_t vt[8];

  // Write / frame_done monitor, sampled on the falling edge.
  always @(negedge pclk) begin
    wr_t w;
    if (we565) begin
      w.a = int'(a565); w.v = d565; q565.push_back(w);
      $display("write dut565 addr=%0d dout=%h", a565, d565);
    end
    if (we444) begin
      w.a = int'(a444); w.v = d444; q444.push_back(w);
      $display("write dut444 addr=%0d dout=%h", a444, d444);
    end
    if (wey8) begin
      w.a = int'(ay8); w.v = dy8; qy8.push_back(w);
      $display("write duty8  addr=%0d dout=%h", ay8, dy8);
    end
    if (wedec) begin
      w.a = int'(adec); w.v = ddec; qdec.push_back(w);
      $display("write dutdec addr=%0d dout=%h", adec, ddec);
    end
    if (fd565) fdc565++;
    if (fd444) fdc444++;
    if (fdy8)  fdcy8++;
    if (fddec) fdcdec++;
  end

  task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    tick(4);
    vsync = 1'b0;
    tick(2);
  endtask

  task automatic put_byte(input logic [7:0] b);
    href = 1'b1;
    d    = b;
    tick(1);
  endtask

  task automatic line_end();
    href = 1'b0;
    d    = 8'h00;
    tick(3);
  endtask

  task automatic clear_mon();
    q565.delete(); q444.delete(); qy8.delete(); qdec.delete();
    fdc565 = 0; fdc444 = 0; fdcy8 = 0; fdcdec = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vt[0] = '{8'hF0, 8'h0F, 16'h0F07, 16'hF00F, 16'h000F};
    vt[1] = '{8'hA5, 8'h3C, 16'h0AAE, 16'hA53C, 16'h003C};
    vt[2] = '{8'h00, 8'h80, 16'h0010, 16'h0080, 16'h0080};
    vt[3] = '{8'hFF, 8'hFF, 16'h0FFF, 16'hFFFF, 16'h00FF};
    vt[4] = '{8'h12, 8'h34, 16'h014A, 16'h1234, 16'h0034};
    vt[5] = '{8'h08, 8'h7F, 16'h000F, 16'h087F, 16'h007F};
    vt[6] = '{8'h87, 8'hE1, 16'h08F0, 16'h87E1, 16'h00E1};
    vt[7] = '{8'h5A, 8'hC3, 16'h0551, 16'h5AC3, 16'h00C3};

    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; d = 8'h00;
    clear_mon();

    // 1: reset held with href toggling -> all outputs zero
    for (int i = 0; i < 10; i++) begin
      href = ~href;
      d    = 8'(i * 37 + 5);
      tick(1);
      cmp("rst_idle", i, {a565, d565, we565, fd565, le565}, 32'h0);
    end
    cmp("rst_writes", 0, q565.size(), 0);
    href  = 1'b0;
    rst_n = 1'b1;
    tick(2);
    vsync_pulse();

    // 2: RGB565 4x2 constant A5/3C
    clear_mon();
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 4; p++) begin
        put_byte(8'hA5);
        put_byte(8'h3C);
      end
      line_end();
    end
    cmp("t2_line_err", 0, le565, 0);
    cmp("t2_done_early", 0, fdc565, 0);
    vsync_pulse();
    cmp("t2_count", 0, q565.size(), 8);
    for (int i = 0; i < q565.size() && i < 8; i++) begin
      cmp("t2_addr", i, q565[i].a, i);
      cmp("t2_dout", i, q565[i].v, 16'hA53C);
    end
    cmp("t2_done", 0, fdc565, 1);

    // 3: table of byte pairs through all three formats
    clear_mon();
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 4; p++) begin
        put_byte(vt[l*4+p].hi);
        put_byte(vt[l*4+p].lo);
      end
      line_end();
    end
    cmp("t3_line_err", 0, le444, 0);
    vsync_pulse();
    cmp("t3_cnt565", 0, q565.size(), 8);
    cmp("t3_cnt444", 0, q444.size(), 8);
    cmp("t3_cnty8", 0, qy8.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < q444.size()) begin
        cmp("t3_addr444", i, q444[i].a, i);
        cmp("t3_rgb444", i, q444[i].v, vt[i].e444);
      end
      if (i < q565.size()) cmp("t3_rgb565", i, q565[i].v, vt[i].e565);
      if (i < qy8.size())  cmp("t3_y8", i, qy8[i].v, vt[i].ey8);
    end
    cmp("t3_done444", 0, fdc444, 1);
    cmp("t3_doney8", 0, fdcy8, 1);

    // 4: 2:1 decimation on an 8x6 frame, data = {y, x}
    clear_mon();
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        put_byte(8'(y));
        put_byte(8'(x));
      end
      line_end();
    end
    cmp("t4_line_err", 0, ledec, 0);
    vsync_pulse();
    cmp("t4_count", 0, qdec.size(), 12);
    k = 0;
    for (int y = 0; y < 6; y += 2) begin
      for (int x = 0; x < 8; x += 2) begin
        if (k < qdec.size()) begin
          cmp("t4_addr", k, qdec[k].a, k);
          cmp("t4_dout", k, qdec[k].v, {8'(y), 8'(x)});
        end
        k++;
      end
    end
    cmp("t4_done", 0, fdcdec, 1);

    // 5: odd-byte line, then short line; error sticky until vsync rise
    clear_mon();
    for (int p = 0; p < 3; p++) begin
      put_byte(8'(8'h10 + p));
      put_byte(8'h20);
    end
    put_byte(8'h99);
    line_end();
    cmp("t5_err_odd", 0, le565, 1);
    for (int p = 0; p < 3; p++) begin
      put_byte(8'(8'h30 + p));
      put_byte(8'h21);
    end
    line_end();
    cmp("t5_err_sticky", 0, le565, 1);
    vsync_pulse();
    cmp("t5_err_clear", 0, le565, 0);
    cmp("t5_count", 0, q565.size(), 6);
    for (int i = 0; i < q565.size() && i < 6; i++) begin
      cmp("t5_addr", i, q565[i].a, i);
      cmp("t5_dout", i, q565[i].v, (i < 3) ? {8'(8'h10 + i), 8'h20} : {8'(8'h30 + i - 3), 8'h21});
    end
    cmp("t5_done", 0, fdc565, 1);

    // 6: reset pulse mid-line
    clear_mon();
    for (int b = 0; b < 5; b++) put_byte(8'(8'hB0 + b));
    line_end();
    cmp("t6_err_before", 0, le565, 1);
    put_byte(8'hC1);
    put_byte(8'hC2);
    put_byte(8'hC3);
    rst_n = 1'b0;
    #1;
    cmp("t6_rst_now", 0, {a565, d565, we565, fd565, le565}, 32'h0);
    tick(1);
    clear_mon();
    rst_n = 1'b1;
    for (int b = 0; b < 5; b++) put_byte(8'(8'hD0 + b));
    line_end();
    for (int b = 0; b < 8; b++) put_byte(8'(8'hE0 + b));
    line_end();
    cmp("t6_no_write", 0, q565.size(), 0);
    cmp("t6_no_err", 0, le565, 0);
    vsync_pulse();
    cmp("t6_no_done", 0, fdc565, 0);
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 4; p++) begin
        put_byte(8'h77);
        put_byte(8'(l * 4 + p));
      end
      line_end();
    end
    cmp("t6_clean_err", 0, le565, 0);
    vsync_pulse();
    cmp("t6_count", 0, q565.size(), 8);
    for (int i = 0; i < q565.size() && i < 8; i++) begin
      cmp("t6_addr", i, q565[i].a, i);
      cmp("t6_dout", i, q565[i].v, {8'h77, 8'(i)});
    end
    cmp("t6_done", 0, fdc565, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
